serial_bit_reverse_rx: RTL and testbench

//  Receiver side of the bit-reversal path. Accepts a 1-bit serial stream and assembles DATA_WIDTH-bit words.

---
 rtl/serial_bit_reverse_rx.sv | 130 +++++++++++++
 tb/tb_serial_bit_reverse_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_reverse_rx.sv
// Serial-to-parallel receiver: assembles din bits into DATA_WIDTH-bit words (bit-reversed or in arrival order)
// behind a one-entry valid/ready output buffer. Optional parity checking is enabled by defining SBR_PARITY_CHECK_EN.
module serial_bit_reverse_rx #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter bit          REVERSE    = 1'b1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                din_valid,
   input  logic                                din,
   output logic                                din_ready,
   output logic [DATA_WIDTH-1:0]               dout,
   output logic                                dout_valid,
   input  logic                                dout_ready,
   output logic [$clog2(DATA_WIDTH+2)-1:0]     bit_count
`ifdef SBR_PARITY_CHECK_EN
   ,
   output logic                                dout_perr
`endif
);

   localparam int unsigned CW = $clog2(DATA_WIDTH + 2);
`ifdef SBR_PARITY_CHECK_EN
   localparam int unsigned WORD_LEN = DATA_WIDTH + 1;
`else
   localparam int unsigned WORD_LEN = DATA_WIDTH;
`endif
   localparam logic [CW-1:0] LAST_IDX = CW'(WORD_LEN - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(WORD_LEN);
   localparam logic [CW-1:0] DATA_CNT = CW'(DATA_WIDTH);
   localparam logic [CW-1:0] TOP_POS  = CW'(DATA_WIDTH - 1);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] word_next;
   logic [CW-1:0]         bit_pos;
   logic                  accept;
   logic                  last_bit;
   logic                  buf_free;
`ifdef SBR_PARITY_CHECK_EN
   logic                  hold_perr;
   logic                  perr_next;
`endif

   // Next word image with the incoming bit placed; the parity bit (index DATA_WIDTH) is never stored.
   always_comb begin
      accept    = din_valid && din_ready;
      last_bit  = (bit_count == LAST_IDX);
      buf_free  = !dout_valid || dout_ready;
      bit_pos   = REVERSE ? bit_count : (TOP_POS - bit_count);
      word_next = shreg;
      if (bit_count < DATA_CNT) begin
         word_next = shreg | (DATA_WIDTH'(din) << bit_pos);
      end
`ifdef SBR_PARITY_CHECK_EN
      perr_next = (^shreg) ^ din;
`endif
   end

   // Collect/hold FSM with the output buffer; a load in the same cycle as a consume overrides the clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= COLLECT;
         din_ready  <= 1'b1;
         shreg      <= '0;
         bit_count  <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
`ifdef SBR_PARITY_CHECK_EN
         hold_perr  <= 1'b0;
         dout_perr  <= 1'b0;
`endif
      end else begin
         if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end
         case (state)
            COLLECT: begin
               if (accept) begin
                  if (last_bit) begin
                     if (buf_free) begin
                        dout       <= word_next;
                        dout_valid <= 1'b1;
                        bit_count  <= '0;
                        shreg      <= '0;
`ifdef SBR_PARITY_CHECK_EN
                        dout_perr  <= perr_next;
`endif
                     end else begin
                        shreg      <= word_next;
                        bit_count  <= FULL_CNT;
                        state      <= HOLD;
                        din_ready  <= 1'b0;
`ifdef SBR_PARITY_CHECK_EN
                        hold_perr  <= perr_next;
`endif
                     end
                  end else begin
                     shreg     <= word_next;
                     bit_count <= bit_count + CW'(1);
                  end
               end
            end
            HOLD: begin
               if (buf_free) begin
                  dout       <= shreg;
                  dout_valid <= 1'b1;
                  bit_count  <= '0;
                  shreg      <= '0;
                  state      <= COLLECT;
                  din_ready  <= 1'b1;
`ifdef SBR_PARITY_CHECK_EN
                  dout_perr  <= hold_perr;
`endif
               end
            end
            default: begin
               state     <= COLLECT;
               din_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_bit_reverse_rx.sv
// Bench for serial_bit_reverse_rx: directed scenarios plus a randomized scoreboard run on a
// REVERSE=1 and a REVERSE=0 instance driven by the same stream.
module tb_serial_bit_reverse_rx;

   localparam int unsigned DW = 8;
`ifdef SBR_PARITY_CHECK_EN
   localparam int unsigned WL = DW + 1;
`else
   localparam int unsigned WL = DW;
`endif
   localparam int unsigned CW = $clog2(DW + 2);

   logic          clk = 1'b0;
   logic          reset;
   logic          din_valid;
   logic          din;
   logic          dout_ready;
   logic          din_ready_r, din_ready_f;
   logic [DW-1:0] dout_r, dout_f;
   logic          dout_valid_r, dout_valid_f;
   logic [CW-1:0] bit_count_r, bit_count_f;
`ifdef SBR_PARITY_CHECK_EN
   logic          perr_r, perr_f;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_bit_reverse_rx #(.DATA_WIDTH(DW), .REVERSE(1'b1)) u_rev (
      .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .din_ready(din_ready_r),
      .dout(dout_r), .dout_valid(dout_valid_r), .dout_ready(dout_ready), .bit_count(bit_count_r)
`ifdef SBR_PARITY_CHECK_EN
      , .dout_perr(perr_r)
`endif
   );

   serial_bit_reverse_rx #(.DATA_WIDTH(DW), .REVERSE(1'b0)) u_fwd (
      .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .din_ready(din_ready_f),
      .dout(dout_f), .dout_valid(dout_valid_f), .dout_ready(dout_ready), .bit_count(bit_count_f)
`ifdef SBR_PARITY_CHECK_EN
      , .dout_perr(perr_f)
`endif
   );

   // Word seen by a REVERSE=0 receiver when the stream is d[0], d[1], ... in time order.
   function automatic logic [DW-1:0] mirror(input logic [DW-1:0] d);
      logic [DW-1:0] m;
      for (int i = 0; i < int'(DW); i++) m[DW-1-i] = d[i];
      return m;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends one word LSB-of-d first (plus parity bit when enabled); optional idle cycle after each bit.
   task automatic send_word(input logic [DW-1:0] d, input logic p, input bit gaps);
      for (int k = 0; k < int'(WL); k++) begin
         if (k < int'(DW)) din = d[k];
         else              din = p;
         din_valid = 1'b1;
         step();
         if (k < int'(WL) - 1) begin
            check("bit_count_inc", 32'(bit_count_r), 32'(k + 1));
            if (gaps) begin
               din_valid = 1'b0;
               din       = ~din;
               step();
               check("bit_count_gap", 32'(bit_count_r), 32'(k + 1));
            end
         end
      end
      din_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      din_valid = 1'b0;
      step();
      reset     = 1'b0;
   endtask

   logic [DW-1:0] exp_q[$];
   logic          exp_perr_q[$];
   logic          bit_q[$];

   initial begin
      logic [DW-1:0] d;
      logic          p;
      int            cyc;

      reset = 1'b1; din_valid = 1'b0; din = 1'b0; dout_ready = 1'b0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      check("rst_dout", 32'(dout_r), 32'(0));
      check("rst_valid", 32'(dout_valid_r), 32'(0));
      check("rst_bit_count", 32'(bit_count_r), 32'(0));
      check("rst_din_ready", 32'(din_ready_r), 32'(1));
`ifdef SBR_PARITY_CHECK_EN
      check("rst_perr", 32'(perr_r), 32'(0));
`endif

      // Stream 1,0,1,1,0,0,0,0: 8'h0D reversed, 8'hB0 in arrival order, valid for one cycle
      dout_ready = 1'b1;
      d = 8'h0D;
      send_word(d, ^d, 1'b0);
      check("t1_valid", 32'(dout_valid_r), 32'(1));
      check("t1_dout_rev", 32'(dout_r), 32'(8'h0D));
      check("t2_dout_fwd", 32'(dout_f), 32'(8'hB0));
      check("t1_bit_count", 32'(bit_count_r), 32'(0));
      step();
      check("t1_valid_drop", 32'(dout_valid_r), 32'(0));

      // Backpressure: second word held, then handed over without a bubble
      dout_ready = 1'b0;
      send_word(8'h0D, 1'b1, 1'b0);
      check("t3_first_valid", 32'(dout_valid_r), 32'(1));
      check("t3_first_ready", 32'(din_ready_r), 32'(1));
      send_word(8'hFF, 1'b0, 1'b0);
      check("t3_hold_ready", 32'(din_ready_r), 32'(0));
      check("t3_hold_dout", 32'(dout_r), 32'(8'h0D));
      check("t3_hold_count", 32'(bit_count_r), 32'(WL));
      din_valid = 1'b1; din = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t3_stable_dout", 32'(dout_r), 32'(8'h0D));
         check("t3_stable_valid", 32'(dout_valid_r), 32'(1));
      end
      din_valid = 1'b0;
      dout_ready = 1'b1;
      step();
      dout_ready = 1'b0;
      check("t3_load_dout", 32'(dout_r), 32'(8'hFF));
      check("t3_load_fwd", 32'(dout_f), 32'(8'hFF));
      check("t3_load_valid", 32'(dout_valid_r), 32'(1));
      check("t3_load_ready", 32'(din_ready_r), 32'(1));
      check("t3_load_count", 32'(bit_count_r), 32'(0));
      dout_ready = 1'b1;
      step();
      check("t3_drain_valid", 32'(dout_valid_r), 32'(0));

      // din_valid gaps inside a word
      send_word(8'hA5, ^(8'hA5), 1'b1);
      check("t4_dout_rev", 32'(dout_r), 32'(8'hA5));
      check("t4_dout_fwd", 32'(dout_f), 32'(mirror(8'hA5)));
      step();

      // Reset mid-word discards the partial word
      for (int k = 0; k < 5; k++) begin
         din = 1'b1; din_valid = 1'b1;
         step();
      end
      check("t5_partial_count", 32'(bit_count_r), 32'(5));
      do_reset();
      step();
      check("t5_rst_count", 32'(bit_count_r), 32'(0));
      check("t5_rst_dout", 32'(dout_r), 32'(0));
      check("t5_rst_valid", 32'(dout_valid_r), 32'(0));
      send_word(8'h3C, ^(8'h3C), 1'b0);
      check("t5_dout_rev", 32'(dout_r), 32'(8'h3C));
      check("t5_dout_fwd", 32'(dout_f), 32'(mirror(8'h3C)));
      step();

`ifdef SBR_PARITY_CHECK_EN
      // Parity: good then bad parity bit on 8'h0D
      send_word(8'h0D, 1'b1, 1'b0);
      check("t6_good_dout", 32'(dout_r), 32'(8'h0D));
      check("t6_good_perr", 32'(perr_r), 32'(0));
      send_word(8'h0D, 1'b0, 1'b0);
      check("t6_bad_dout", 32'(dout_r), 32'(8'h0D));
      check("t6_bad_perr", 32'(perr_r), 32'(1));
      check("t6_bad_perr_fwd", 32'(perr_f), 32'(1));
      step();
`endif

      // Randomized stream with random gaps and backpressure against a word-level scoreboard
      for (int w = 0; w < 24; w++) begin
         d = DW'($urandom);
         p = 1'($urandom);
         for (int k = 0; k < int'(DW); k++) bit_q.push_back(d[k]);
`ifdef SBR_PARITY_CHECK_EN
         bit_q.push_back(p);
`endif
         exp_q.push_back(d);
         exp_perr_q.push_back((^d) ^ p);
      end
      cyc = 0;
      while ((bit_q.size() > 0 || exp_q.size() > 0) && cyc < 4000) begin
         din_valid  = (bit_q.size() > 0) && ($urandom_range(0, 3) != 0);
         din        = (bit_q.size() > 0) ? bit_q[0] : 1'b0;
         dout_ready = (bit_q.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (dout_valid_r && dout_ready) begin
            if (exp_q.size() == 0) begin
               check("rnd_extra_word", 32'(1), 32'(0));
            end else begin
               check("rnd_dout_rev", 32'(dout_r), 32'(exp_q[0]));
               check("rnd_dout_fwd", 32'(dout_f), 32'(mirror(exp_q[0])));
`ifdef SBR_PARITY_CHECK_EN
               check("rnd_perr", 32'(perr_r), 32'(exp_perr_q[0]));
`endif
               void'(exp_q.pop_front());
               void'(exp_perr_q.pop_front());
            end
         end
         if (din_valid && din_ready_r) void'(bit_q.pop_front());
         step();
         check("rnd_count_range", 32'(bit_count_r <= CW'(WL)), 32'(1));
         cyc++;
      end
      check("rnd_words_left", 32'(exp_q.size()), 32'(0));
      check("rnd_bits_left", 32'(bit_q.size()), 32'(0));
      din_valid = 1'b0;
      step();
      check("rnd_final_valid", 32'(dout_valid_r), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
